// File: rtl/adder_amba_pkg.sv
// Shared register map, AXI response codes and FSM encodings
// for the adder AXI4-Lite master sequencer.
package adder_amba_pkg;

  localparam logic [7:0] ADDR_R0   = 8'h00;
  localparam logic [7:0] ADDR_R1   = 8'h04;
  localparam logic [7:0] ADDR_R2   = 8'h08;
  localparam logic [7:0] ADDR_CTRL = 8'h0C;
  localparam logic [7:0] ADDR_LEDS = 8'h10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_OP_BIT    = 1;
  localparam int STAT_DONE_BIT  = 31;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_R0,
    ST_WR_R1,
    ST_WR_CTRL,
    ST_POLL,
    ST_RD_R2,
    ST_RESP
  } step_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_RESP,
    S_R_ADDR,
    S_R_DATA,
    S_RESP
  } state_e;

  function automatic logic [31:0] ctrl_word(input logic op);
    logic [31:0] w;
    w = '0;
    w[CTRL_START_BIT] = 1'b1;
    w[CTRL_OP_BIT]    = op;
    return w;
  endfunction

endpackage

// File: rtl/adder_axil_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface adder_axil_master_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arprot, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_single_xfer.sv
// Runs one AXI4-Lite read or write; done is combinational so
// the sequencer can chain the next transfer with no idle gap.
module axil_single_xfer
  import adder_amba_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    resp,
  adder_axil_master_if.master m
);

  state_e        state_q, state_d;
  logic          awv_q, awv_d;
  logic          wv_q, wv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_W_ADDR: begin
        // AW and W retire independently, in any order
        if (m.awready) awv_d = 1'b0;
        if (m.wready)  wv_d  = 1'b0;
        if (!awv_d && !wv_d) state_d = S_W_RESP;
      end
      S_W_RESP: if (m.bvalid)  state_d = S_IDLE;
      S_R_ADDR: if (m.arready) state_d = S_R_DATA;
      S_R_DATA: if (m.rvalid)  state_d = S_IDLE;
      default: ;
    endcase
    if (start) begin
      addr_d  = addr;
      wdata_d = wdata;
      if (is_write) begin
        state_d = S_W_ADDR;
        awv_d   = 1'b1;
        wv_d    = 1'b1;
      end else begin
        state_d = S_R_ADDR;
      end
    end
  end

  assign done = (state_q == S_W_RESP && m.bvalid) ||
                (state_q == S_R_DATA && m.rvalid);
  assign rdata = m.rdata;
  assign resp  = (state_q == S_W_RESP) ? m.bresp : m.rresp;

  assign m.awaddr  = addr_q;
  assign m.awprot  = 3'b000;
  assign m.awvalid = awv_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = '1;
  assign m.wvalid  = wv_q;
  assign m.bready  = (state_q == S_W_RESP);
  assign m.araddr  = addr_q;
  assign m.arprot  = 3'b000;
  assign m.arvalid = (state_q == S_R_ADDR);
  assign m.rready  = (state_q == S_R_DATA);

endmodule

// File: rtl/adder_axil_master.sv
// Request/response sequencer that drives adder_amba_top through
// write r0, write r1, start, poll status, read r2.
module adder_axil_master
  import adder_amba_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int POLL_MAX           = 16
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_op,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_result,
  output logic        o_err,
  adder_axil_master_if.master m_axi
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  step_e         step_q, step_d;
  logic [DW-1:0] b_q, b_d;
  logic          op_q, op_d;
  logic [15:0]   poll_q, poll_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;

  logic          x_start, x_wr, x_done, fail;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;
  logic [1:0]    x_resp;

  axil_single_xfer #(.AW(AW), .DW(DW)) u_xfer (
    .clk      (M_AXI_ACLK),
    .rst      (M_AXI_ARESET),
    .start    (x_start),
    .is_write (x_wr),
    .addr     (x_addr),
    .wdata    (x_wdata),
    .done     (x_done),
    .rdata    (x_rdata),
    .resp     (x_resp),
    .m        (m_axi)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      step_q <= ST_IDLE;
      b_q    <= '0;
      op_q   <= 1'b0;
      poll_q <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      b_q    <= b_d;
      op_q   <= op_d;
      poll_q <= poll_d;
      res_q  <= res_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    step_d  = step_q;
    b_d     = b_q;
    op_d    = op_q;
    poll_d  = poll_q;
    res_d   = res_q;
    err_d   = err_q;
    x_start = 1'b0;
    x_wr    = 1'b0;
    x_addr  = '0;
    x_wdata = '0;
    fail    = 1'b0;
    unique case (step_q)
      ST_IDLE: if (i_valid) begin
        // operand A lives in the transfer engine's data register
        b_d     = i_b;
        op_d    = i_op;
        poll_d  = '0;
        res_d   = '0;
        err_d   = 1'b0;
        x_start = 1'b1;
        x_wr    = 1'b1;
        x_addr  = AW'(ADDR_R0);
        x_wdata = i_a;
        step_d  = ST_WR_R0;
      end
      ST_WR_R0: if (x_done) begin
        if (x_resp != RESP_OKAY) fail = 1'b1;
        else begin
          x_start = 1'b1;
          x_wr    = 1'b1;
          x_addr  = AW'(ADDR_R1);
          x_wdata = b_q;
          step_d  = ST_WR_R1;
        end
      end
      ST_WR_R1: if (x_done) begin
        if (x_resp != RESP_OKAY) fail = 1'b1;
        else begin
          x_start = 1'b1;
          x_wr    = 1'b1;
          x_addr  = AW'(ADDR_CTRL);
          x_wdata = DW'(ctrl_word(op_q));
          step_d  = ST_WR_CTRL;
        end
      end
      ST_WR_CTRL: if (x_done) begin
        if (x_resp != RESP_OKAY) fail = 1'b1;
        else begin
          x_start = 1'b1;
          x_addr  = AW'(ADDR_CTRL);
          step_d  = ST_POLL;
        end
      end
      ST_POLL: if (x_done) begin
        poll_d = poll_q + 16'd1;
        if (x_resp != RESP_OKAY) fail = 1'b1;
        else if (x_rdata[STAT_DONE_BIT]) begin
          x_start = 1'b1;
          x_addr  = AW'(ADDR_R2);
          step_d  = ST_RD_R2;
        end else if (poll_d == 16'(POLL_MAX)) begin
          fail = 1'b1;
        end else begin
          x_start = 1'b1;
          x_addr  = AW'(ADDR_CTRL);
        end
      end
      ST_RD_R2: if (x_done) begin
        if (x_resp != RESP_OKAY) fail = 1'b1;
        else begin
          res_d  = x_rdata;
          step_d = ST_RESP;
        end
      end
      ST_RESP: if (o_ready) step_d = ST_IDLE;
      default: step_d = ST_IDLE;
    endcase
    if (fail) begin
      err_d  = 1'b1;
      res_d  = '0;
      step_d = ST_RESP;
    end
  end

  assign i_ready  = (step_q == ST_IDLE);
  assign o_valid  = (step_q == ST_RESP);
  assign o_result = res_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_adder_axil_master.sv
// Directed bench with a behavioural adder slave and a result scoreboard.
module tb_adder_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_op;
  logic [31:0] i_a, i_b;
  logic        o_valid, o_ready, o_err;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_axil_master_if #(.AW(5), .DW(32)) axi ();

  adder_axil_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (5),
    .POLL_MAX           (4)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_op         (i_op),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_result     (o_result),
    .o_err        (o_err),
    .m_axi        (axi)
  );

  // slave configuration, written only by the stimulus
  int   aw_delay   = 0;
  int   poll_delay = 0;
  logic err_addr4  = 1'b0;
  logic never_done = 1'b0;

  // slave state
  int          aw_cnt;
  logic        aw_got, w_got, bv, rv, started;
  logic [4:0]  aw_a;
  logic [31:0] w_dat, rd, r0, r1, r2;
  logic [1:0]  br, ctrl;
  int          polls_left;
  logic [36:0] wr_log[$];
  int aw_hs_n = 0, ar_n = 0, ar_stat_n = 0;
  int aw_wait_n = 0, wv_n = 0, unstable_n = 0;
  logic        awv_p, awr_p, wv_p, wr_p;
  logic [4:0]  awa_p;
  logic [31:0] wd_p;

  logic        aw_ok, w_ok, stat_done;
  logic [4:0]  aw_eff;
  logic [31:0] w_eff;

  assign axi.awready = (aw_cnt >= aw_delay);
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;
  assign axi.bvalid  = bv;
  assign axi.bresp   = br;
  assign axi.rvalid  = rv;
  assign axi.rdata   = rd;
  assign axi.rresp   = 2'b00;

  assign aw_ok  = aw_got | (axi.awvalid & axi.awready);
  assign w_ok   = w_got | (axi.wvalid & axi.wready);
  assign aw_eff = aw_got ? aw_a : axi.awaddr;
  assign w_eff  = w_got ? w_dat : axi.wdata;
  assign stat_done = started && !never_done && (polls_left == 0);

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; aw_got <= 0; w_got <= 0; bv <= 0; br <= 0;
      rv <= 0; rd <= 0; started <= 0; polls_left <= 0;
      r0 <= 0; r1 <= 0; r2 <= 0; ctrl <= 0;
      awv_p <= 0; wv_p <= 0; awr_p <= 0; wr_p <= 0;
    end else begin
      if (awv_p && !awr_p && (!axi.awvalid || axi.awaddr != awa_p))
        unstable_n <= unstable_n + 1;
      if (wv_p && !wr_p && (!axi.wvalid || axi.wdata != wd_p))
        unstable_n <= unstable_n + 1;
      awv_p <= axi.awvalid; awr_p <= axi.awready; awa_p <= axi.awaddr;
      wv_p <= axi.wvalid; wr_p <= axi.wready; wd_p <= axi.wdata;
      if (axi.wvalid) wv_n <= wv_n + 1;
      if (axi.awvalid && axi.awready) begin
        aw_cnt <= 0;
        aw_hs_n <= aw_hs_n + 1;
      end else if (axi.awvalid) begin
        aw_cnt <= aw_cnt + 1;
        aw_wait_n <= aw_wait_n + 1;
      end
      if (bv && axi.bready) bv <= 1'b0;
      if (aw_ok && w_ok && !bv) begin
        bv <= 1'b1;
        br <= (err_addr4 && aw_eff == 5'h04) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        wr_log.push_back({aw_eff, w_eff});
        case (aw_eff)
          5'h00: r0 <= w_eff;
          5'h04: r1 <= w_eff;
          5'h0C: begin
            ctrl <= w_eff[1:0];
            if (w_eff[0]) begin
              r2 <= w_eff[1] ? r0 + r1 : r0 - r1;
              started <= 1'b1;
              polls_left <= poll_delay;
            end
          end
          default: ;
        endcase
      end else begin
        if (axi.awvalid && axi.awready) begin
          aw_got <= 1'b1; aw_a <= axi.awaddr;
        end
        if (axi.wvalid && axi.wready) begin
          w_got <= 1'b1; w_dat <= axi.wdata;
        end
      end
      if (rv && axi.rready) rv <= 1'b0;
      if (axi.arvalid && axi.arready && !rv) begin
        rv <= 1'b1;
        ar_n <= ar_n + 1;
        if (axi.araddr == 5'h0C) begin
          ar_stat_n <= ar_stat_n + 1;
          rd <= {stat_done, 29'b0, ctrl};
          if (polls_left > 0) polls_left <= polls_left - 1;
        end else if (axi.araddr == 5'h08) rd <= r2;
        else rd <= 32'h0;
      end
    end
  end

  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input int idx, input logic [4:0] a,
                          input logic [31:0] d);
    logic [36:0] e;
    e = (idx < wr_log.size()) ? wr_log[idx] : 37'h1f_ffff_ffff;
    check($sformatf("wr%0d_addr", idx), 32'(e[36:32]), 32'(a));
    check($sformatf("wr%0d_data", idx), e[31:0], d);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic e_err,
                        input logic [31:0] e_res, input int rdly);
    logic [32:0] exp;
    int n;
    exp_q.push_back({e_err, e_res});
    @(negedge clk);
    i_a = a; i_b = b; i_op = op; i_valid = 1'b1;
    n = 0;
    while (!i_ready && n < 50) begin @(negedge clk); n++; end
    check("req_accept", 32'(i_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 3000) begin @(negedge clk); n++; end
    check("resp_seen", 32'(o_valid), 32'd1);
    exp = exp_q.pop_front();
    for (int k = 0; k < rdly; k++) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_result", o_result, exp[31:0]);
      check("hold_err", 32'(o_err), 32'(exp[32]));
      @(negedge clk);
    end
    check("o_result", o_result, exp[31:0]);
    check("o_err", 32'(o_err), 32'(exp[32]));
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    check("o_valid_drop", 32'(o_valid), 32'd0);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_awvalid"}, 32'(axi.awvalid), 32'd0);
    check({tag, "_wvalid"}, 32'(axi.wvalid), 32'd0);
    check({tag, "_arvalid"}, 32'(axi.arvalid), 32'd0);
    check({tag, "_bready"}, 32'(axi.bready), 32'd0);
    check({tag, "_rready"}, 32'(axi.rready), 32'd0);
    check({tag, "_i_ready"}, 32'(i_ready), 32'd1);
    check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    int idx, s0, s1, s2, n;
    logic found;
    rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_op = 1'b0;
    o_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_bus("reset");
    check("reset_o_err", 32'(o_err), 32'd0);
    check("reset_o_result", o_result, 32'd0);
    check("reset_awaddr", 32'(axi.awaddr), 32'd0);
    check("reset_araddr", 32'(axi.araddr), 32'd0);
    check("reset_wdata", axi.wdata, 32'd0);
    check("reset_prot", 32'({axi.awprot, axi.arprot}), 32'd0);
    check("reset_wstrb", 32'(axi.wstrb), 32'hF);

    // subtract with a slave that needs three status reads
    poll_delay = 2;
    idx = wr_log.size(); s0 = ar_stat_n;
    do_req(32'd2, 32'd1, 1'b0, 1'b0, 32'd1, 0);
    check("sub_nwrites", 32'(wr_log.size() - idx), 32'd3);
    check_wr(idx, 5'h00, 32'd2);
    check_wr(idx + 1, 5'h04, 32'd1);
    check_wr(idx + 2, 5'h0C, 32'h1);
    check("sub_polls", 32'(ar_stat_n - s0), 32'd3);

    // add with 32-bit wrap
    poll_delay = 0;
    idx = wr_log.size();
    do_req(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd0, 0);
    check_wr(idx + 2, 5'h0C, 32'h3);

    // AWREADY held off for 5 cycles per write
    aw_delay = 5;
    s0 = wv_n; s1 = aw_wait_n; s2 = unstable_n;
    do_req(32'd10, 32'd7, 1'b1, 1'b0, 32'd17, 0);
    check("bp_wvalid_cycles", 32'(wv_n - s0), 32'd3);
    check("bp_aw_wait_cycles", 32'(aw_wait_n - s1), 32'd15);
    check("bp_unstable", 32'(unstable_n - s2), 32'd0);
    aw_delay = 0;

    // slave error on the r1 write
    err_addr4 = 1'b1;
    s0 = aw_hs_n; s1 = ar_n;
    do_req(32'd9, 32'd4, 1'b0, 1'b1, 32'd0, 0);
    check("err_aw_count", 32'(aw_hs_n - s0), 32'd2);
    check("err_ar_count", 32'(ar_n - s1), 32'd0);
    err_addr4 = 1'b0;

    // poll timeout, response held under backpressure
    never_done = 1'b1;
    s0 = ar_stat_n;
    do_req(32'd1, 32'd1, 1'b1, 1'b1, 32'd0, 3);
    check("timeout_polls", 32'(ar_stat_n - s0), 32'd4);

    // reset while polling, then a fresh request
    @(negedge clk);
    i_a = 32'd8; i_b = 32'd1; i_op = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      @(negedge clk); n++;
      found = axi.arvalid && axi.araddr == 5'h0C;
    end
    check("mid_poll_seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_bus("midrst");
    never_done = 1'b0;
    do_req(32'd5, 32'd3, 1'b0, 1'b0, 32'd2, 0);

    check("total_unstable", 32'(unstable_n), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
